alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control decoder, plus two register operands.
- Produces a registered result, zero and overflow flags.
- Single-cycle ops complete in 1 clock. MULT runs as an iterative shift-add over WIDTH clocks, with a start/busy/done handshake toward the pipeline control.

Parameters:
- WIDTH, 16, operand/result width in bits (power of 2, >= 4).
- SHW, log2(WIDTH) = 4, shift-amount width taken from b[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on clk edge when busy=0.
- alu_control  input  4  operation code, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B / shift amount, sampled with start.
- result  output  WIDTH  registered result (low WIDTH bits for MULT).
- hi  output  WIDTH  upper WIDTH bits of MULT product; 0 for other ops.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow for ADD/ADDI/SUB, else 0.
- illegal  output  1  code not in the decode table below.
- busy  output  1  multiplication in progress.
- done  output  1  one-cycle pulse; outputs valid and updated.

Behaviour:
- Reset (rst_n=0, asynchronous): result=0, hi=0, zero=0, overflow=0, illegal=0, busy=0, done=0. State goes to IDLE and the iteration counter is cleared. Reset mid-MULT aborts the operation; no done is produced.
- Decode table:
  - 0000 AND
  - 0010 OR
  - 0001 SLL (a << b[SHW-1:0])
  - 0110 SRL (logical a >> b[SHW-1:0])
  - 0100 ADD, 0101 ADDI: a+b modulo 2^WIDTH
  - 1100 SUB: a-b modulo 2^WIDTH
  - 0111 MULT: unsigned a*b, 2*WIDTH-bit product split hi:result
  - Any other code: result=0, hi=0, illegal=1, done pulses as for a single-cycle op.
- Overflow:
  - ADD/ADDI: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
- zero is evaluated on the final result only (hi ignored).
- States: IDLE, MUL.
- IDLE, start=1, non-MULT code:
  - result/flags registered at edge E0; done=1 during the cycle after E0.
  - State stays IDLE, so back-to-back starts give one result per clock.
- IDLE, start=1, MULT code:
  - At E0: capture a/b into internal regs, clear accumulator, counter=0, busy=1, state to MUL, done=0.
  - Outputs retain their previous values while busy.
- MUL:
  - Each edge performs one iteration: if multiplier LSB is 1, add multiplicand into the accumulator upper half; shift right; counter+1.
  - At edge E_WIDTH (counter reaches WIDTH-1 before the edge): load result/hi/zero, overflow=0, illegal=0, busy=0, done=1 for one cycle, state to IDLE.
  - Total: busy high for exactly WIDTH cycles; done in cycle WIDTH after start.
- start while busy=1 is ignored; no queuing and no side effects.
- start in the cycle where done=1 (busy=0) is accepted normally.
- done is never high for two consecutive cycles unless two single-cycle starts occur back-to-back.
- Outputs other than done hold their value until the next completion.
- Shift amounts use only the low SHW bits of b, so a shift of WIDTH or more is impossible. SLL/SRL fill with zeros.

Test Plan:
- ADD a=0x7FFF, b=0x0001, start 1 cycle → next cycle done=1, result=0x8000, overflow=1, zero=0, busy=0.
- SUB a=0x0005, b=0x0005, then same cycle-next AND a=0xF0F0, b=0x0FF0 back-to-back → done two consecutive cycles; result 0x0000 with zero=1, then 0x00F0 with zero=0.
- MULT a=0x1234, b=0x0010 → busy high 16 cycles, done in cycle 16, result=0x2340, hi=0x0001; MULT 0xFFFF*0xFFFF → hi=0xFFFE, result=0x0001.
- During MULT, pulse start with ADD a=1, b=1 at cycle 5 → ignored; MULT result unchanged, single done at cycle 16.
- Reset asserted asynchronously mid-MULT at cycle 7 → all outputs 0 immediately, no done; after release, ADD 2+3 → result=0x0005 next cycle.
- SLL a=0x0001, b=0x0013 → result=0x0008; SRL a=0x8000, b=0x000F → 0x0001; code 1111 → illegal=1, result=0, done pulses.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between pipeline control and the execute-stage ALU.
interface alu_exec_unit_if #(parameter int WIDTH = 16);
   logic             start;
   logic [3:0]       alu_control;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic             zero;
   logic             overflow;
   logic             illegal;
   logic             busy;
   logic             done;

   modport master (output start, alu_control, a, b,
                   input  result, hi, zero, overflow, illegal, busy, done);
   modport slave  (input  start, alu_control, a, b,
                   output result, hi, zero, overflow, illegal, busy, done);
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/shift/add ops plus an iterative
// shift-add unsigned multiplier that takes WIDTH clocks.
module alu_exec_unit #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_exec_unit_if.slave bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_ADDI = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b1100;
   localparam logic [3:0] OP_MULT = 4'b0111;

   logic [0:0]         state_q;
   logic [SHW-1:0]     cnt_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   result_q, hi_q;
   logic               zero_q, ovf_q, ill_q, busy_q, done_q;

   logic [WIDTH-1:0]   op_res_d;
   logic               op_ovf_d, op_ill_d;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] acc_d;

   wire sa = bus.a[WIDTH-1];
   wire sb = bus.b[WIDTH-1];

   always_comb begin
      op_res_d = '0;
      op_ovf_d = 1'b0;
      op_ill_d = 1'b0;
      case (bus.alu_control)
         OP_AND:  op_res_d = bus.a & bus.b;
         OP_OR:   op_res_d = bus.a | bus.b;
         OP_SLL:  op_res_d = bus.a << bus.b[SHW-1:0];
         OP_SRL:  op_res_d = bus.a >> bus.b[SHW-1:0];
         OP_ADD, OP_ADDI: begin
            op_res_d = bus.a + bus.b;
            op_ovf_d = (sa == sb) && (op_res_d[WIDTH-1] != sa);
         end
         OP_SUB: begin
            op_res_d = bus.a - bus.b;
            op_ovf_d = (sa != sb) && (op_res_d[WIDTH-1] != sa);
         end
         default: op_ill_d = 1'b1;
      endcase
   end

   // Multiplier lives in the low half of acc_q and drains out as the
   // partial product shifts in from the top.
   always_comb begin
      add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_d   = {add_sum, acc_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.alu_control == OP_MULT) begin
                     mcand_q <= bus.a;
                     acc_q   <= {{WIDTH{1'b0}}, bus.b};
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_MUL;
                  end else begin
                     result_q <= op_res_d;
                     hi_q     <= '0;
                     zero_q   <= (op_res_d == '0);
                     ovf_q    <= op_ovf_d;
                     ill_q    <= op_ill_d;
                     done_q   <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == SHW'(WIDTH-1)) begin
                  result_q <= acc_d[WIDTH-1:0];
                  hi_q     <= acc_d[2*WIDTH-1:WIDTH];
                  zero_q   <= (acc_d[WIDTH-1:0] == '0);
                  ovf_q    <= 1'b0;
                  ill_q    <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.result   = result_q;
   assign bus.hi       = hi_q;
   assign bus.zero     = zero_q;
   assign bus.overflow = ovf_q;
   assign bus.illegal  = ill_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops plus
// hand sequences for multiply, ignored start, back-to-back and reset abort.
module tb_alu_exec_unit;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   logic [15:0] last_res;

   alu_exec_unit_if #(.WIDTH(16)) bus ();
   alu_exec_unit #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] a, b, res;
      logic        zero, ovf, ill;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one start at a negedge; returns at the negedge after the capturing edge.
   task automatic issue(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.alu_control = code; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eres, input logic [15:0] ehi,
                           input logic ezero, input bit inject);
      int cycles = 0;
      int early = 0;
      int holderr = 0;
      issue(4'b0111, a, b);
      while (bus.busy && cycles < 40) begin
         if (bus.done) early++;
         if (bus.result !== last_res) holderr++;
         if (inject && cycles == 4) begin
            bus.start = 1'b1; bus.alu_control = 4'b0100; bus.a = 16'd1; bus.b = 16'd1;
         end else bus.start = 1'b0;
         @(negedge clk);
         cycles++;
      end
      bus.start = 1'b0;
      chk("mult_busy_cycles", cycles, 16);
      chk("mult_no_early_done", early, 0);
      chk("mult_hold_outputs", holderr, 0);
      chk("mult_done", {31'b0, bus.done}, 1);
      chk("mult_result", {16'b0, bus.result}, {16'b0, eres});
      chk("mult_hi", {16'b0, bus.hi}, {16'b0, ehi});
      chk("mult_flags", {29'b0, bus.zero, bus.overflow, bus.illegal}, {29'b0, ezero, 2'b00});
      @(negedge clk);
      chk("mult_single_done", {31'b0, bus.done}, 0);
      chk("mult_result_held", {16'b0, bus.result}, {16'b0, eres});
      last_res = eres;
   endtask

   initial begin
      vecs[0] = '{4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{4'b0001, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{4'b0110, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{4'b0010, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{4'b0101, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{4'b1100, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{4'b0000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{4'b0011, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[9] = '{4'b1100, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};

      bus.start = 1'b0; bus.alu_control = '0; bus.a = '0; bus.b = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_outputs", {bus.result, bus.hi[9:0], bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done, 1'b0}, 32'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      last_res = 16'h0;

      foreach (vecs[i]) begin
         issue(vecs[i].code, vecs[i].a, vecs[i].b);
         chk($sformatf("vec%0d_result", i), {16'b0, bus.result}, {16'b0, vecs[i].res});
         chk($sformatf("vec%0d_flags", i), {27'b0, bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done},
             {27'b0, vecs[i].zero, vecs[i].ovf, vecs[i].ill, 2'b01});
         chk($sformatf("vec%0d_hi", i), {16'b0, bus.hi}, 32'h0);
         last_res = vecs[i].res;
      end
      @(negedge clk);
      chk("done_drops", {31'b0, bus.done}, 0);

      // Back-to-back single-cycle ops: SUB then AND on consecutive edges.
      @(negedge clk);
      bus.start = 1'b1; bus.alu_control = 4'b1100; bus.a = 16'h0005; bus.b = 16'h0005;
      @(negedge clk);
      chk("b2b_sub", {15'b0, bus.done, bus.result}, {15'b0, 1'b1, 16'h0000});
      chk("b2b_sub_zero", {31'b0, bus.zero}, 1);
      bus.alu_control = 4'b0000; bus.a = 16'hF0F0; bus.b = 16'h0FF0;
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_and", {15'b0, bus.done, bus.result}, {15'b0, 1'b1, 16'h00F0});
      chk("b2b_and_zero", {31'b0, bus.zero}, 0);
      last_res = 16'h00F0;

      run_mult(16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 1'b0);
      run_mult(16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
      run_mult(16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0);
      run_mult(16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 1'b1);

      // Single-cycle op right in the done cycle of a multiply is accepted.
      issue(4'b0111, 16'h0003, 16'h0004);
      for (int i = 0; i < 15; i++) @(negedge clk);
      bus.start = 1'b1; bus.alu_control = 4'b0100; bus.a = 16'h0010; bus.b = 16'h0020;
      @(negedge clk);
      chk("done_cycle_mult", {15'b0, bus.done, bus.result}, {15'b0, 1'b1, 16'h000C});
      @(negedge clk);
      bus.start = 1'b0;
      chk("done_cycle_add", {15'b0, bus.done, bus.result}, {15'b0, 1'b1, 16'h0030});
      chk("done_cycle_add_hi", {16'b0, bus.hi}, 32'h0);

      // Asynchronous reset mid-multiply aborts without a done.
      issue(4'b0111, 16'h1234, 16'h0010);
      for (int i = 0; i < 6; i++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", {bus.result, bus.hi[10:0], bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done},
          32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", {30'b0, bus.busy, bus.done}, 0);
      end
      rst_n = 1'b1;
      issue(4'b0100, 16'h0002, 16'h0003);
      chk("post_reset_add", {15'b0, bus.done, bus.result}, {15'b0, 1'b1, 16'h0005});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) chk("post_reset_quiet", {30'b0, bus.busy, bus.done}, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
